// File: rtl/fib_sched_if.sv
// Request/response and engine handshake bundle for the fibonacci scheduler.
// The scheduler binds to the slave modport; requesters and the engine sit on the master side.
interface fib_sched_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 16
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_din;
    logic [N_REQ-1:0]       req_ack;
    logic [N_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]       rsp_data;
    logic                   rsp_err;
    logic                   eng_start;
    logic [WIDTH-1:0]       eng_din;
    logic [WIDTH-1:0]       eng_dout;
    logic                   eng_done;
    logic                   busy;

    modport slave (
        input  req_valid, req_din, eng_dout, eng_done,
        output req_ack, rsp_valid, rsp_data, rsp_err, eng_start, eng_din, busy
    );

    modport master (
        output req_valid, req_din, eng_dout, eng_done,
        input  req_ack, rsp_valid, rsp_data, rsp_err, eng_start, eng_din, busy
    );
endinterface

// File: rtl/fib_sched.sv
// Round-robin scheduler sharing one fibonacci engine among N_REQ requesters,
// with a start/done handshake, a watchdog timeout and one-cycle response pulses.
module fib_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    fib_sched_if.slave  bus
);
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} state_t;

    state_t         state;
    logic [IW-1:0]  winner;
    logic [IW-1:0]  last_served;
    logic [IW-1:0]  pick;
    logic           pick_ok;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] result;
    logic           err;
    int unsigned    idx;

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
        onehot = N_REQ'(1) << i;
    endfunction

    // Round-robin search starting just after the last requester served
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(last_served) + 32'd1 + k) % N_REQ;
            if (!pick_ok && bus.req_valid[IW'(idx)]) begin
                pick    = IW'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            winner        <= '0;
            last_served   <= IW'(N_REQ - 1);
            cnt           <= '0;
            result        <= '0;
            err           <= 1'b0;
            bus.req_ack   <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.eng_start <= 1'b0;
            bus.eng_din   <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.req_ack   <= '0;
            bus.rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        winner        <= pick;
                        bus.eng_din   <= bus.req_din[32'(pick)*WIDTH +: WIDTH];
                        bus.req_ack   <= onehot(pick);
                        bus.eng_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        cnt           <= '0;
                        err           <= 1'b0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.eng_done) begin
                        result        <= bus.eng_dout;
                        bus.eng_start <= 1'b0;
                        state         <= RELEASE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        result        <= '0;
                        err           <= 1'b1;
                        bus.eng_start <= 1'b0;
                        state         <= RELEASE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Hold until the engine drops done so the next start sees a clean rise
                RELEASE: begin
                    if (!bus.eng_done) begin
                        bus.rsp_valid <= onehot(winner);
                        bus.rsp_data  <= result;
                        bus.rsp_err   <= err;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    bus.rsp_data <= '0;
                    bus.rsp_err  <= 1'b0;
                    last_served  <= winner;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_sched.sv
// Directed bench for fib_sched: behavioural fibonacci engine, protocol monitor,
// and hand-computed expectations for latency, arbitration order, timeout and reset.
module tb_fib_sched;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fib_sched_if #(.N_REQ(N), .WIDTH(W)) bus();

    fib_sched #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Engine model: reset is the inverted scheduler reset; done after eng_lat cycles
    logic        eng_rst;
    int unsigned eng_lat  = 1;
    logic        eng_hang = 1'b0;
    logic        eng_active = 1'b0;
    int unsigned eng_cnt = 0;
    logic [W-1:0] eng_res = '0;
    assign eng_rst = ~reset_n;

    function automatic logic [W-1:0] fib(input logic [W-1:0] n);
        logic [W-1:0] a, b, t;
        a = '0;
        b = W'(1);
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge clk or posedge eng_rst) begin
        if (eng_rst) begin
            eng_active   <= 1'b0;
            eng_cnt      <= 0;
            bus.eng_done <= 1'b0;
            bus.eng_dout <= '0;
        end else if (bus.eng_start && !eng_active && !bus.eng_done) begin
            eng_active <= 1'b1;
            eng_cnt    <= eng_lat - 1;
            eng_res    <= fib(bus.eng_din);
        end else if (eng_active && !bus.eng_start) begin
            eng_active <= 1'b0;
        end else if (eng_active && !eng_hang) begin
            if (eng_cnt == 0) begin
                eng_active   <= 1'b0;
                bus.eng_done <= 1'b1;
                bus.eng_dout <= eng_res;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end else if (bus.eng_done && !bus.eng_start) begin
            bus.eng_done <= 1'b0;
        end
    end

    // Protocol monitor: one-hot pulses, clean start rise, operand stability
    int   ack_cnt [N] = '{default: 0};
    int   rsp_cnt [N] = '{default: 0};
    int   proto_err = 0;
    logic prev_start = 1'b0;
    logic prev_busy  = 1'b0;
    logic [W-1:0] prev_din = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (!$onehot0(bus.req_ack) || !$onehot0(bus.rsp_valid)) proto_err++;
            if (bus.eng_start && !prev_start && bus.eng_done) proto_err++;
            if (bus.busy && prev_busy && bus.eng_din != prev_din) proto_err++;
        end
        for (int i = 0; i < int'(N); i++) begin
            ack_cnt[i] += int'(bus.req_ack[i]);
            rsp_cnt[i] += int'(bus.rsp_valid[i]);
        end
        prev_start = bus.eng_start;
        prev_busy  = bus.busy;
        prev_din   = bus.eng_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] oh(input int unsigned k);
        return 32'(1) << k;
    endfunction

    task automatic wait_ack(input string tag, output int unsigned cyc);
        cyc = 0;
        while (bus.req_ack == '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ack_seen"}, 32'(bus.req_ack != '0), 32'(1));
    endtask

    task automatic wait_rsp(input string tag, output int unsigned cyc);
        cyc = 0;
        while (bus.rsp_valid == '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_rsp_seen"}, 32'(bus.rsp_valid != '0), 32'(1));
    endtask

    task automatic run_job(input string tag, input int unsigned r, input logic [W-1:0] din,
                           input int unsigned lat, input logic [W-1:0] exp_data,
                           input logic exp_err, input int unsigned exp_lat);
        int unsigned cyc;
        eng_lat = lat;
        bus.req_din[r*W +: W] = din;
        bus.req_valid[r] = 1'b1;
        wait_ack(tag, cyc);
        check({tag, "_ack"},    32'(bus.req_ack), oh(r));
        check({tag, "_engdin"}, 32'(bus.eng_din), 32'(din));
        check({tag, "_start"},  32'(bus.eng_start), 32'(1));
        bus.req_valid[r] = 1'b0;
        wait_rsp(tag, cyc);
        check({tag, "_rspv"},   32'(bus.rsp_valid), oh(r));
        check({tag, "_data"},   32'(bus.rsp_data), 32'(exp_data));
        check({tag, "_err"},    32'(bus.rsp_err), 32'(exp_err));
        check({tag, "_lat"},    32'(cyc), 32'(exp_lat));
        @(negedge clk);
        check({tag, "_pulse1"}, 32'(bus.rsp_valid), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   32'(bus.req_ack), 32'(0));
        check({tag, "_rspv"},  32'(bus.rsp_valid), 32'(0));
        check({tag, "_data"},  32'(bus.rsp_data), 32'(0));
        check({tag, "_err"},   32'(bus.rsp_err), 32'(0));
        check({tag, "_start"}, 32'(bus.eng_start), 32'(0));
        check({tag, "_engdin"},32'(bus.eng_din), 32'(0));
        check({tag, "_busy"},  32'(bus.busy), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        int a3, r3, rsum;
        int exp_f [4] = '{5, 8, 13, 21};

        bus.req_valid = '0;
        bus.req_din   = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Single job: fib(10)=55, engine latency 1 -> rsp 5 cycles after ack
        run_job("single", 2, W'(10), 1, W'(55), 1'b0, 5);

        // Boundary operands
        run_job("din0",  0, W'(0),  1, W'(0),     1'b0, 5);
        run_job("din1",  1, W'(1),  2, W'(1),     1'b0, 6);
        run_job("din2",  3, W'(2),  3, W'(1),     1'b0, 7);
        run_job("din24", 0, W'(24), 1, W'(46368), 1'b0, 5);

        // Fairness: fresh reset, all four pending, two rounds
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        eng_lat = 2;
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 4; k++) bus.req_din[k*W +: W] = W'(5 + k);
            bus.req_valid = 4'b1111;
            for (int k = 0; k < 4; k++) begin
                wait_ack("fair", cyc);
                check("fair_order", 32'(bus.req_ack), oh(k));
                bus.req_valid = bus.req_valid & ~bus.req_ack;
                wait_rsp("fair", cyc);
                check("fair_rspv", 32'(bus.rsp_valid), oh(k));
                check("fair_data", 32'(bus.rsp_data), 32'(exp_f[k]));
            end
            @(negedge clk);
        end

        // Operand change after ack and a request withdrawn before ack
        a3 = ack_cnt[3];
        r3 = rsp_cnt[3];
        eng_lat = 6;
        bus.req_din[0 +: W] = W'(9);
        bus.req_valid[0] = 1'b1;
        wait_ack("drop", cyc);
        check("drop_ack", 32'(bus.req_ack), oh(0));
        bus.req_valid[0] = 1'b0;
        bus.req_din[0 +: W] = W'(20);
        bus.req_valid[3] = 1'b1;
        repeat (2) @(negedge clk);
        bus.req_valid[3] = 1'b0;
        wait_rsp("drop", cyc);
        check("drop_rspv", 32'(bus.rsp_valid), oh(0));
        check("drop_data", 32'(bus.rsp_data), 32'(34));
        repeat (6) @(negedge clk);
        check("drop_no_ack3", 32'(ack_cnt[3] - a3), 32'(0));
        check("drop_no_rsp3", 32'(rsp_cnt[3] - r3), 32'(0));
        check("drop_idle", 32'(bus.busy), 32'(0));

        // Timeout: engine never completes, abort at 16 cycles after start
        eng_hang = 1'b1;
        run_job("tmo", 1, W'(7), 1, W'(0), 1'b1, 17);
        eng_hang = 1'b0;
        run_job("after_tmo", 1, W'(7), 2, W'(13), 1'b0, 6);

        // Reset in the middle of ISSUE
        run_job("pre_rst", 0, W'(3), 1, W'(2), 1'b0, 5);
        eng_lat = 10;
        bus.req_din[2*W +: W] = W'(12);
        bus.req_valid[2] = 1'b1;
        wait_ack("midrst", cyc);
        bus.req_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_start", 32'(bus.eng_start), 32'(1));
        rsum = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3];
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_rsp", 32'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3] - rsum), 32'(0));
        check("midrst_idle_start", 32'(bus.eng_start), 32'(0));
        eng_lat = 2;
        bus.req_din[0 +: W] = W'(4);
        bus.req_din[W +: W] = W'(5);
        bus.req_valid = 4'b0011;
        wait_ack("post0", cyc);
        check("post0_ack", 32'(bus.req_ack), oh(0));
        bus.req_valid = bus.req_valid & ~bus.req_ack;
        wait_rsp("post0", cyc);
        check("post0_data", 32'(bus.rsp_data), 32'(3));
        wait_ack("post1", cyc);
        check("post1_ack", 32'(bus.req_ack), oh(1));
        bus.req_valid = bus.req_valid & ~bus.req_ack;
        wait_rsp("post1", cyc);
        check("post1_data", 32'(bus.rsp_data), 32'(5));
        repeat (3) @(negedge clk);

        check("protocol", 32'(proto_err), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
